// File: rtl/io_output_bank_if.sv
// Data-memory-side bus for the output port bank: address, write data,
// byte enables, read/write strobes and the registered readback.
interface io_output_bank_if #(
   parameter int DATA_W = 32
);
   logic [31:0]         addr;
   logic [31:0]         datain;
   logic [DATA_W/8-1:0] byte_en;
   logic                write_io_enable;
   logic                read_io_enable;
   logic [DATA_W-1:0]   io_read_data;

   modport master (
      output addr, datain, byte_en, write_io_enable, read_io_enable,
      input  io_read_data
   );

   modport slave (
      input  addr, datain, byte_en, write_io_enable, read_io_enable,
      output io_read_data
   );
endinterface

// File: rtl/io_output_bank.sv
// Memory-mapped output port bank. NPORTS registers of DATA_W bits at word
// indices BASE_IDX.., written with byte enables in one of four modes
// (write/set/clear/toggle, chosen by addr[9:8]), with registered
// read-before-write readback and a one-cycle update pulse per port.
module io_output_bank #(
   parameter int          DATA_W    = 32,
   parameter int          NPORTS    = 3,
   parameter int          BASE_IDX  = 32,
   parameter logic [31:0] RESET_VAL = '0
) (
   input  logic                     io_clk,
   input  logic                     resetn,
   io_output_bank_if.slave          bus,
   output logic [NPORTS*DATA_W-1:0] out_ports,
   output logic [NPORTS-1:0]        port_updated
);

   localparam int LANES = DATA_W / 8;

   typedef enum logic [1:0] {
      MODE_WRITE  = 2'b00,
      MODE_SET    = 2'b01,
      MODE_CLEAR  = 2'b10,
      MODE_TOGGLE = 2'b11
   } mode_e;

   logic [NPORTS-1:0][DATA_W-1:0] port_q;
   logic [NPORTS-1:0]             sel;
   logic [DATA_W-1:0]             mask;
   logic [DATA_W-1:0]             wdata;
   logic [DATA_W-1:0]             rd_mux;
   logic [DATA_W-1:0]             rd_q;
   logic [6:0]                    word;
   mode_e                         mode;

   assign word  = {1'b0, bus.addr[7:2]};
   assign mode  = mode_e'(bus.addr[9:8]);
   assign wdata = bus.datain[DATA_W-1:0];

   // Address bits outside the word/mode fields carry no meaning here.
   logic unused_addr;
   assign unused_addr = ^{bus.addr[31:10], bus.addr[1:0]};

   generate
      if (DATA_W < 32) begin : g_unused_hi
         logic unused_hi;
         assign unused_hi = ^bus.datain[31:DATA_W];
      end
   endgenerate

   // Expand each byte enable into an 8-bit lane of the write mask.
   genvar l;
   generate
      for (l = 0; l < LANES; l++) begin : g_mask
         assign mask[l*8 +: 8] = {8{bus.byte_en[l]}};
      end
   endgenerate

   // One-hot port select; an address outside the bank selects nothing.
   always_comb begin
      sel = '0;
      for (int p = 0; p < NPORTS; p++)
         sel[p] = (word == 7'(BASE_IDX + p));
   end

   // Readback mux of current (pre-write) contents; a miss reads zero.
   always_comb begin
      rd_mux = '0;
      for (int p = 0; p < NPORTS; p++)
         if (sel[p]) rd_mux = port_q[p];
   end

   function automatic logic [DATA_W-1:0] apply_mode(
      input mode_e             md,
      input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] d,
      input logic [DATA_W-1:0] m
   );
      logic [DATA_W-1:0] dm;
      dm = d & m;
      case (md)
         MODE_WRITE: apply_mode = (old & ~m) | dm;
         MODE_SET:   apply_mode = old | dm;
         MODE_CLEAR: apply_mode = old & ~dm;
         default:    apply_mode = old ^ dm;
      endcase
   endfunction

   // Port registers and update pulses; a hit always pulses, even with an
   // empty mask, because the write was accepted.
   always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn) begin
         for (int p = 0; p < NPORTS; p++)
            port_q[p] <= RESET_VAL[DATA_W-1:0];
         port_updated <= '0;
      end else begin
         for (int p = 0; p < NPORTS; p++) begin
            port_updated[p] <= bus.write_io_enable & sel[p];
            if (bus.write_io_enable && sel[p])
               port_q[p] <= apply_mode(mode, port_q[p], wdata, mask);
         end
      end
   end

   // Registered readback; holds when no read is strobed.
   always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn)                 rd_q <= '0;
      else if (bus.read_io_enable) rd_q <= rd_mux;
   end

   assign bus.io_read_data = rd_q;
   assign out_ports        = port_q;

endmodule

// File: tb/tb_io_output_bank.sv
// Bench for io_output_bank (DATA_W=32, NPORTS=3, BASE_IDX=32): directed
// cases from the feature list followed by random traffic against a simple
// array model of the port contents.
module tb_io_output_bank;

   logic io_clk = 1'b0;
   logic resetn = 1'b0;
   logic [95:0] out_ports;
   logic [2:0]  port_updated;

   io_output_bank_if #(.DATA_W(32)) bus ();

   io_output_bank #(
      .DATA_W(32), .NPORTS(3), .BASE_IDX(32), .RESET_VAL(32'h0)
   ) dut (
      .io_clk(io_clk),
      .resetn(resetn),
      .bus(bus),
      .out_ports(out_ports),
      .port_updated(port_updated)
   );

   always #5 io_clk = ~io_clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [0:2];
   logic [2:0]  exp_upd;
   logic [31:0] exp_rd;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".ports"}, out_ports, {model[2], model[1], model[0]});
      check({tag, ".upd"}, {93'd0, port_updated}, {93'd0, exp_upd});
      check({tag, ".rd"}, {64'd0, bus.io_read_data}, {64'd0, exp_rd});
   endtask

   // One bus cycle: drive while the clock is low, predict, check after the edge.
   task automatic step(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic we, input logic re);
      int w;
      logic [31:0] m, dm, old;
      @(negedge io_clk);
      bus.addr = a; bus.datain = d; bus.byte_en = be;
      bus.write_io_enable = we; bus.read_io_enable = re;
      w = int'(a[7:2]) - 32;
      m = 32'h0;
      for (int k = 0; k < 4; k++) if (be[k]) m[k*8 +: 8] = 8'hFF;
      dm = d & m;
      old = (w >= 0 && w < 3) ? model[w] : 32'h0;
      if (re) exp_rd = old;
      exp_upd = 3'b000;
      if (we && w >= 0 && w < 3) begin
         exp_upd[w] = 1'b1;
         case (a[9:8])
            2'd0: model[w] = (old & ~m) | dm;
            2'd1: model[w] = old | dm;
            2'd2: model[w] = old & ~dm;
            default: model[w] = old ^ dm;
         endcase
      end
      @(posedge io_clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] ra;
      bus.addr = '0; bus.datain = '0; bus.byte_en = '0;
      bus.write_io_enable = 1'b0; bus.read_io_enable = 1'b0;
      for (int i = 0; i < 3; i++) model[i] = 32'h0;
      exp_upd = 3'b000;
      exp_rd  = 32'h0;

      // Reset state
      #12;
      check_all("reset");
      @(negedge io_clk);
      resetn = 1'b1;

      // Full word write to port1
      step("full_wr", 32'h84, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
      check("full_p1", {64'd0, out_ports[63:32]}, {64'd0, 32'hDEADBEEF});
      check("full_upd", {93'd0, port_updated}, {93'd0, 3'b010});
      idle("full_after");

      // Partial write to port0
      step("part_init", 32'h80, 32'h11223344, 4'hF, 1'b1, 1'b0);
      step("part_wr", 32'h80, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
      check("part_p0", {64'd0, out_ports[31:0]}, {64'd0, 32'h11BB33DD});

      // Bit modes on port2
      step("bm_init", 32'h88, 32'h000000F0, 4'hF, 1'b1, 1'b0);
      step("bm_set", 32'h188, 32'h0F, 4'hF, 1'b1, 1'b0);
      check("set_p2", {64'd0, out_ports[95:64]}, {64'd0, 32'hFF});
      step("bm_clr", 32'h288, 32'h30, 4'hF, 1'b1, 1'b0);
      check("clr_p2", {64'd0, out_ports[95:64]}, {64'd0, 32'hCF});
      step("bm_tog", 32'h388, 32'hFF, 4'hF, 1'b1, 1'b0);
      check("tog_p2", {64'd0, out_ports[95:64]}, {64'd0, 32'h30});

      // Empty mask on a hit still pulses
      step("be0", 32'h84, 32'h12345678, 4'h0, 1'b1, 1'b0);
      check("be0_upd", {93'd0, port_updated}, {93'd0, 3'b010});

      // Read-before-write
      step("rbw_init", 32'h80, 32'h5, 4'hF, 1'b1, 1'b0);
      step("rbw_same", 32'h80, 32'h9, 4'hF, 1'b1, 1'b1);
      check("rbw_old", {64'd0, bus.io_read_data}, {64'd0, 32'h5});
      step("rbw_next", 32'h80, 32'h0, 4'h0, 1'b0, 1'b1);
      check("rbw_new", {64'd0, bus.io_read_data}, {64'd0, 32'h9});

      // Mode alias read, then hold with read disabled
      step("alias_rd", 32'h388, 32'h0, 4'h0, 1'b0, 1'b1);
      idle("rd_hold");

      // Consecutive writes keep the pulse high
      step("cons1", 32'h88, 32'h1, 4'hF, 1'b1, 1'b0);
      step("cons2", 32'h88, 32'h2, 4'hF, 1'b1, 1'b0);

      // Misses above and below the bank
      step("miss_hi", 32'h8C, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
      check("miss_hi_rd", {64'd0, bus.io_read_data}, 96'd0);
      check("miss_hi_upd", {93'd0, port_updated}, 96'd0);
      step("miss_lo", 32'h7C, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
      check("miss_lo_rd", {64'd0, bus.io_read_data}, 96'd0);

      // Random traffic around the bank, with junk in ignored address bits
      for (int i = 0; i < 300; i++) begin
         ra = $urandom;
         ra[7:2] = 6'(30 + $urandom_range(0, 6));
         step("rand", ra, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
      end

      // Asynchronous reset mid-cycle, during an active write
      @(negedge io_clk);
      bus.addr = 32'h80; bus.datain = 32'hA5A5A5A5; bus.byte_en = 4'hF;
      bus.write_io_enable = 1'b1; bus.read_io_enable = 1'b1;
      @(posedge io_clk);
      #3;
      resetn = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) model[i] = 32'h0;
      exp_upd = 3'b000;
      exp_rd  = 32'h0;
      check_all("async_rst");
      @(negedge io_clk);
      bus.write_io_enable = 1'b0; bus.read_io_enable = 1'b0;
      resetn = 1'b1;

      // Write right after reset release is honoured
      step("post_rst", 32'h84, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
      idle("end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
